// File: rtl/status_report_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : status_report_tx_if
// Description : Character stream handshake from the report formatter to the
//               UART transmitter byte port.
// Revision    : 1.0 - initial release
// ============================================================================
interface status_report_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/status_report_tx.sv
`default_nettype none
// ============================================================================
// Module      : status_report_tx
// Description : Formats LED / 7-segment state into "LD: 0xHHHH\r\n" and
//               "SG: 0xHHHH\r\n" lines and streams them to the UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
module status_report_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LED_COUNT  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 ena,
    input  wire logic [LED_COUNT-1:0] led_data,
    input  wire logic [15:0]          seg_data,
    input  wire logic                 report_req,
    status_report_tx_if.master        tx,
    output logic                      busy
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_send  = 1'b1;
    localparam logic [3:0] c_last_idx = 4'd11;

    logic [0:0]  r_state;
    logic [3:0]  r_idx;
    logic        r_sel;        // 0 = LD message, 1 = SG message
    logic [15:0] r_snap;
    logic [15:0] r_led_prev;
    logic [15:0] r_seg_prev;
    logic        r_led_pend;
    logic        r_seg_pend;

    logic [0:0]  w_state_nxt;
    logic [3:0]  w_idx_nxt;
    logic        w_sel_nxt;
    logic [15:0] w_snap_nxt;
    logic        w_led_clr;
    logic        w_seg_clr;
    logic [15:0] w_led_ext;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hex;
    logic [7:0]  w_char;

    if (LED_COUNT < 16) begin : g_led_pad
        assign w_led_ext = {{(16-LED_COUNT){1'b0}}, led_data};
    end else begin : g_led_full
        assign w_led_ext = led_data;
    end

    // Change detection and pending flags run regardless of ena; a set on the
    // same edge as the snapshot clear wins so the report is resent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_prev <= 16'h0000;
            r_seg_prev <= 16'h0000;
            r_led_pend <= 1'b0;
            r_seg_pend <= 1'b0;
        end else begin
            r_led_prev <= w_led_ext;
            r_seg_prev <= seg_data;
            r_led_pend <= (r_led_pend & ~w_led_clr) | (w_led_ext != r_led_prev) | report_req;
            r_seg_pend <= (r_seg_pend & ~w_seg_clr) | (seg_data != r_seg_prev) | report_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_idx   <= 4'd0;
            r_sel   <= 1'b0;
            r_snap  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_sel   <= w_sel_nxt;
            r_snap  <= w_snap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sel_nxt   = r_sel;
        w_snap_nxt  = r_snap;
        w_led_clr   = 1'b0;
        w_seg_clr   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (ena && (r_led_pend || r_seg_pend)) begin
                    w_state_nxt = c_st_send;
                    w_idx_nxt   = 4'd0;
                    if (r_led_pend) begin
                        w_sel_nxt  = 1'b0;
                        w_snap_nxt = w_led_ext;
                        w_led_clr  = 1'b1;
                    end else begin
                        w_sel_nxt  = 1'b1;
                        w_snap_nxt = seg_data;
                        w_seg_clr  = 1'b1;
                    end
                end
            end
            c_st_send: begin
                if (tx.tx_ready) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = c_st_idle;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_nibble = 4'h0;
        case (r_idx)
            4'd6:    w_nibble = r_snap[15:12];
            4'd7:    w_nibble = r_snap[11:8];
            4'd8:    w_nibble = r_snap[7:4];
            4'd9:    w_nibble = r_snap[3:0];
            default: w_nibble = 4'h0;
        endcase
    end

    assign w_hex = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                      : (8'h37 + {4'h0, w_nibble});

    always_comb begin
        w_char = 8'h00;
        if (r_state == c_st_send) begin
            case (r_idx)
                4'd0:    w_char = r_sel ? 8'h53 : 8'h4C;  // 'S' / 'L'
                4'd1:    w_char = r_sel ? 8'h47 : 8'h44;  // 'G' / 'D'
                4'd2:    w_char = 8'h3A;
                4'd3:    w_char = 8'h20;
                4'd4:    w_char = 8'h30;
                4'd5:    w_char = 8'h78;
                4'd10:   w_char = 8'h0D;
                4'd11:   w_char = 8'h0A;
                default: w_char = w_hex;
            endcase
        end
    end

    assign tx.tx_data  = DATA_WIDTH'(w_char);
    assign tx.tx_valid = (r_state == c_st_send);
    assign busy        = (r_state == c_st_send);

endmodule
`default_nettype wire

// File: tb/tb_status_report_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_report_tx
// Description : Directed self-checking bench for status_report_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_report_tx;

    logic        clk;
    logic        reset;
    logic        ena;
    logic [15:0] led_data;
    logic [15:0] seg_data;
    logic        report_req;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [95:0] rx_msg;

    status_report_tx_if #(.DATA_WIDTH(8)) bus ();

    status_report_tx #(
        .DATA_WIDTH (8),
        .LED_COUNT  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .led_data   (led_data),
        .seg_data   (seg_data),
        .report_req (report_req),
        .tx         (bus.master),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] make_msg(input bit is_seg, input logic [15:0] v);
        string hx;
        logic [95:0] m;
        hx = "0123456789ABCDEF";
        m = {(is_seg ? 16'h5347 : 16'h4C44), 8'h3A, 8'h20, 8'h30, 8'h78,
             hx[v[15:12]], hx[v[11:8]], hx[v[7:4]], hx[v[3:0]], 8'h0D, 8'h0A};
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receives one 12-char message; mode 0 = ready held high, 1 = ready toggling.
    // When char chg_idx is accepted, led_data is changed to chg_val.
    task automatic recv(input int mode, input int chg_idx, input logic [15:0] chg_val,
                        output int wait_cyc, output int nvalid, output int bad, output bit tmo);
        int cnt;
        logic stall;
        logic [7:0] pd;
        cnt = 0; wait_cyc = 0; nvalid = 0; bad = 0; tmo = 1'b0;
        stall = 1'b0; pd = 8'h00; rx_msg = '0;
        for (int c = 0; c < 400; c++) begin
            bus.tx_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            if (!bus.tx_valid && cnt == 0) wait_cyc++;
            if (!bus.tx_valid && cnt > 0) bad++;
            if (bus.tx_valid) begin
                nvalid++;
                if (stall && bus.tx_data !== pd) bad++;
            end
            if (busy !== bus.tx_valid) bad++;
            stall = bus.tx_valid && !bus.tx_ready;
            pd    = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                rx_msg[95-8*cnt -: 8] = bus.tx_data;
                if (cnt == chg_idx) led_data = chg_val;
                cnt++;
            end
            step();
            if (cnt == 12) break;
        end
        if (cnt != 12) tmo = 1'b1;
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b data=%h, want 0 0 00",
                     bus.tx_valid, busy, bus.tx_data);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.tx_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: got valid=%b, want 0", i, bus.tx_valid);
            end
        end
    endtask

    task automatic test_led_basic();
        int w, nv, bad;
        bit tmo;
        led_data = 16'h00A5;
        step();
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL led_latency_e: got valid=%b, want 0", bus.tx_valid);
        end
        step();
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4C) begin
            n_errors++;
            $display("FAIL led_latency_e1: got valid=%b data=%h, want 1 4c", bus.tx_valid, bus.tx_data);
        end
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b0, 16'h00A5)) begin
            n_errors++;
            $display("FAIL led_msg: got %h, want %h", rx_msg, make_msg(1'b0, 16'h00A5));
        end
        n_checks++;
        if (nv != 12 || bad != 0) begin
            n_errors++;
            $display("FAIL led_valid_cycles: got %0d (bad %0d), want 12 (bad 0)", nv, bad);
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL led_end_idle: got valid=%b, want 0", bus.tx_valid);
        end
    endtask

    task automatic test_seg_toggle();
        int w, nv, bad;
        bit tmo;
        seg_data = 16'hBEEF;
        recv(1, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b1, 16'hBEEF)) begin
            n_errors++;
            $display("FAIL seg_msg: got %h, want %h", rx_msg, make_msg(1'b1, 16'hBEEF));
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL seg_stable: got %0d violations, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int w, nv, bad;
        bit tmo;
        led_data = 16'h1234;
        seg_data = 16'hCAFE;
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b0, 16'h1234)) begin
            n_errors++;
            $display("FAIL b2b_ld: got %h, want %h", rx_msg, make_msg(1'b0, 16'h1234));
        end
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b1, 16'hCAFE)) begin
            n_errors++;
            $display("FAIL b2b_sg: got %h, want %h", rx_msg, make_msg(1'b1, 16'hCAFE));
        end
        n_checks++;
        if (w != 1) begin
            n_errors++;
            $display("FAIL b2b_gap: got %0d idle cycles, want 1", w);
        end
    endtask

    task automatic test_mid_change();
        int w, nv, bad;
        bit tmo;
        led_data = 16'h0001;
        recv(0, 5, 16'h0002, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b0, 16'h0001)) begin
            n_errors++;
            $display("FAIL mid_first: got %h, want %h", rx_msg, make_msg(1'b0, 16'h0001));
        end
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b0, 16'h0002) || w != 1) begin
            n_errors++;
            $display("FAIL mid_second: got %h gap %0d, want %h gap 1", rx_msg, w, make_msg(1'b0, 16'h0002));
        end
    endtask

    task automatic test_ena();
        int w, nv, bad, seen;
        bit tmo;
        ena = 1'b0;
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tx_valid) seen++;
            step();
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL ena_hold: got %0d valid cycles, want 0", seen);
        end
        ena = 1'b1;
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b0, 16'h0002)) begin
            n_errors++;
            $display("FAIL ena_ld: got %h, want %h", rx_msg, make_msg(1'b0, 16'h0002));
        end
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b1, 16'hCAFE)) begin
            n_errors++;
            $display("FAIL ena_sg: got %h, want %h", rx_msg, make_msg(1'b1, 16'hCAFE));
        end
    endtask

    task automatic test_reset_mid();
        int w, nv, bad, seen, guard;
        bit tmo;
        report_req = 1'b1;
        step();
        report_req = 1'b0;
        guard = 0;
        while (!bus.tx_valid && guard < 20) begin
            step();
            guard++;
        end
        n_checks++;
        if (!bus.tx_valid) begin
            n_errors++;
            $display("FAIL rmid_start: got valid=0, want 1 within 20 cycles");
        end
        for (int i = 0; i < 7; i++) step();
        n_checks++;
        if (bus.tx_data !== 8'h30) begin
            n_errors++;
            $display("FAIL rmid_char7: got %h, want 30", bus.tx_data);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_drop: got valid=%b busy=%b, want 0 0", bus.tx_valid, busy);
        end
        led_data = 16'h0000;
        seg_data = 16'h0000;
        step();
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_valid) seen++;
            step();
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL rmid_quiet: got %0d valid cycles, want 0", seen);
        end
        led_data = 16'h0007;
        recv(0, -1, 16'h0, w, nv, bad, tmo);
        n_checks++;
        if (tmo || rx_msg !== make_msg(1'b0, 16'h0007) || w != 2) begin
            n_errors++;
            $display("FAIL rmid_after: got %h wait %0d, want %h wait 2", rx_msg, w, make_msg(1'b0, 16'h0007));
        end
    endtask

    initial begin
        reset = 1'b1;
        ena = 1'b1;
        led_data = 16'h0000;
        seg_data = 16'h0000;
        report_req = 1'b0;
        bus.tx_ready = 1'b1;
        step();
        step();
        test_reset();
        test_led_basic();
        test_seg_toggle();
        test_back_to_back();
        test_mid_change();
        test_ena();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
